// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch stage: datapath width, NOP encoding,
// reset PC, the per-edge fetch operation and a saturating-increment helper.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int CNT_W = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // What the fetch stage does on the next edge; flush outranks stall.
  typedef enum logic [1:0] {
    OP_ADVANCE = 2'd0,
    OP_STALL   = 2'd1,
    OP_FLUSH   = 2'd2
  } fetch_op_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard controls in, ROM port, IF/ID outputs and debug counters.
interface fetch_stage_if #(
  parameter int XLEN = riscv_pkg::XLEN
);
  logic            Cr_pipeline_stop;
  logic [XLEN-1:0] redirect_pc;
  logic            stall;
  logic [XLEN-1:0] irom_addr;
  logic [XLEN-1:0] irom_inst;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_pc4;
  logic [XLEN-1:0] id_inst;
  logic            id_valid;
  logic [31:0]     flush_cnt;
  logic [31:0]     stall_cnt;

  modport slave (
    input  Cr_pipeline_stop, redirect_pc, stall, irom_inst,
    output irom_addr, id_pc, id_pc4, id_inst, id_valid, flush_cnt, stall_cnt
  );

  modport master (
    output Cr_pipeline_stop, redirect_pc, stall, irom_inst,
    input  irom_addr, id_pc, id_pc4, id_inst, id_valid, flush_cnt, stall_cnt
  );
endinterface

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register: loads either the sequential PC or a redirect target.
module pc_reg #(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_en,
  input  logic            sel_redirect,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] pc
);

  // PC update: hold when not enabled, otherwise pick redirect or pc+4.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load_en) begin
      pc <= sel_redirect ? redirect_target : pc_plus4;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, next-PC selection, ROM address, IF/ID register
// and saturating flush/stall event counters.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input logic          clk,
  input logic          rst_n,
  fetch_stage_if.slave bus
);

  fetch_op_e       op;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] redirect_target;
  logic [XLEN-1:0] id_pc_q;
  logic [XLEN-1:0] id_pc4_q;
  logic [XLEN-1:0] id_inst_q;
  logic            id_valid_q;
  logic [31:0]     flush_q;
  logic [31:0]     stall_q;

  // Decide this edge's operation; the redirecting instruction is older, so flush wins.
  always_comb begin
    op = OP_ADVANCE;
    if (bus.Cr_pipeline_stop) begin
      op = OP_FLUSH;
    end else if (bus.stall) begin
      op = OP_STALL;
    end
  end

  assign pc_plus4        = pc + XLEN'(4);
  assign redirect_target = {bus.redirect_pc[XLEN-1:2], 2'b00};

  pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk             (clk),
    .rst_n           (rst_n),
    .load_en         (op != OP_STALL),
    .sel_redirect    (op == OP_FLUSH),
    .pc_plus4        (pc_plus4),
    .redirect_target (redirect_target),
    .pc              (pc)
  );

  // IF/ID pipeline register: bubble on flush, hold on stall, capture fetch on advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_pc_q    <= '0;
      id_pc4_q   <= '0;
      id_inst_q  <= XLEN'(NOP_INST);
      id_valid_q <= 1'b0;
    end else begin
      case (op)
        OP_FLUSH: begin
          id_pc_q    <= '0;
          id_pc4_q   <= '0;
          id_inst_q  <= XLEN'(NOP_INST);
          id_valid_q <= 1'b0;
        end
        OP_ADVANCE: begin
          id_pc_q    <= pc;
          id_pc4_q   <= pc_plus4;
          id_inst_q  <= bus.irom_inst;
          id_valid_q <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Performance counters: a flush cycle counts only as a flush, never as a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_q <= '0;
      stall_q <= '0;
    end else begin
      if (op == OP_FLUSH) flush_q <= sat_inc(flush_q);
      if (op == OP_STALL) stall_q <= sat_inc(stall_q);
    end
  end

  assign bus.irom_addr = pc;
  assign bus.id_pc     = id_pc_q;
  assign bus.id_pc4    = id_pc4_q;
  assign bus.id_inst   = id_inst_q;
  assign bus.id_valid  = id_valid_q;
  assign bus.flush_cnt = flush_q;
  assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: behavioural reference model checked every
// cycle, plus hand-computed literal expectations at key points.
module tb_fetch_stage;

  localparam logic [31:0] ROM_KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  fetch_stage_if #(.XLEN(32)) bus ();

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.irom_inst = bus.irom_addr ^ ROM_KEY;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [31:0] m_pc    = 32'h0;
  logic [31:0] m_idpc  = 32'h0;
  logic [31:0] m_idpc4 = 32'h0;
  logic [31:0] m_inst  = NOP;
  logic        m_valid = 1'b0;
  logic [31:0] m_fcnt  = 32'h0;
  logic [31:0] m_scnt  = 32'h0;

  task automatic model_reset();
    m_pc = 32'h0; m_idpc = 32'h0; m_idpc4 = 32'h0;
    m_inst = NOP; m_valid = 1'b0; m_fcnt = 32'h0; m_scnt = 32'h0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge rst_n) model_reset();

  // model: next state from the fetch rules, computed with plain arithmetic
  always @(posedge clk) begin
    if (!rst_n) begin
      model_reset();
    end else if (bus.Cr_pipeline_stop) begin
      m_pc    = bus.redirect_pc & 32'hFFFF_FFFC;
      m_idpc  = 32'h0;
      m_idpc4 = 32'h0;
      m_inst  = NOP;
      m_valid = 1'b0;
      if (m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 1;
    end else if (bus.stall) begin
      if (m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
    end else begin
      m_idpc  = m_pc;
      m_idpc4 = m_pc + 32'd4;
      m_inst  = m_pc ^ ROM_KEY;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
    end
  end

  // per-cycle compare against the model
  always @(posedge clk) begin
    #1;
    chk("m_irom_addr", bus.irom_addr, m_pc);
    chk("m_id_pc",     bus.id_pc,     m_idpc);
    chk("m_id_pc4",    bus.id_pc4,    m_idpc4);
    chk("m_id_inst",   bus.id_inst,   m_inst);
    chk("m_id_valid",  {31'b0, bus.id_valid}, {31'b0, m_valid});
    chk("m_flush_cnt", bus.flush_cnt, m_fcnt);
    chk("m_stall_cnt", bus.stall_cnt, m_scnt);
  end

  // set inputs at a falling edge, then move to the next falling edge
  task automatic cyc(input logic cf, input logic [31:0] rp, input logic st);
    bus.Cr_pipeline_stop = cf;
    bus.redirect_pc      = rp;
    bus.stall            = st;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.Cr_pipeline_stop = 1'b0;
    bus.redirect_pc      = 32'h0;
    bus.stall            = 1'b0;

    @(negedge clk);
    chk("rst_addr",  bus.irom_addr, 32'h0);
    chk("rst_inst",  bus.id_inst,   32'h0000_0013);
    chk("rst_valid", {31'b0, bus.id_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // free-run
    chk("run_addr0",  bus.irom_addr, 32'h0);
    chk("run_valid0", {31'b0, bus.id_valid}, 32'h0);
    cyc(1'b0, 32'h0, 1'b0);
    chk("run_addr4",  bus.irom_addr, 32'h4);
    chk("run_valid1", {31'b0, bus.id_valid}, 32'h1);
    chk("run_idpc",   bus.id_pc,   32'h0);
    chk("run_inst",   bus.id_inst, 32'hA5A5_0000);
    chk("run_pc4",    bus.id_pc4,  32'h4);
    cyc(1'b0, 32'h0, 1'b0);
    chk("run_addr8",  bus.irom_addr, 32'h8);
    cyc(1'b0, 32'h0, 1'b0);
    chk("run_addr12", bus.irom_addr, 32'hC);
    cyc(1'b0, 32'h0, 1'b0);
    chk("run_addr16", bus.irom_addr, 32'h10);

    // redirect with misaligned target
    cyc(1'b1, 32'h103, 1'b0);
    chk("redir_addr",  bus.irom_addr, 32'h100);
    chk("redir_valid", {31'b0, bus.id_valid}, 32'h0);
    chk("redir_inst",  bus.id_inst, 32'h0000_0013);
    chk("redir_fcnt",  bus.flush_cnt, 32'h1);
    cyc(1'b0, 32'h0, 1'b0);
    chk("redir_idpc",  bus.id_pc, 32'h100);

    // get PC to 0x20 with a live instruction in IF/ID, then stall 3 cycles
    cyc(1'b1, 32'h1C, 1'b0);
    cyc(1'b0, 32'h0, 1'b0);
    chk("pre_stall_addr", bus.irom_addr, 32'h20);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 32'h0, 1'b1);
      chk("stall_addr", bus.irom_addr, 32'h20);
      chk("stall_idpc", bus.id_pc, 32'h1C);
      chk("stall_inst", bus.id_inst, 32'hA5A5_001C);
      chk("stall_valid", {31'b0, bus.id_valid}, 32'h1);
    end
    chk("stall_cnt3", bus.stall_cnt, 32'h3);
    cyc(1'b0, 32'h0, 1'b0);
    chk("unstall_idpc", bus.id_pc, 32'h20);

    // simultaneous stall and flush
    cyc(1'b1, 32'h40, 1'b1);
    chk("both_addr",  bus.irom_addr, 32'h40);
    chk("both_valid", {31'b0, bus.id_valid}, 32'h0);
    chk("both_fcnt",  bus.flush_cnt, 32'h3);
    chk("both_scnt",  bus.stall_cnt, 32'h3);

    // PC wrap
    cyc(1'b1, 32'hFFFF_FFFC, 1'b0);
    cyc(1'b0, 32'h0, 1'b0);
    chk("wrap_addr", bus.irom_addr, 32'h0);
    chk("wrap_idpc", bus.id_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4",  bus.id_pc4, 32'h0);
    chk("wrap_inst", bus.id_inst, 32'h5A5A_FFFC);

    // flush counter saturation
    force dut.flush_q = 32'hFFFF_FFFF;
    #1;
    release dut.flush_q;
    m_fcnt = 32'hFFFF_FFFF;
    cyc(1'b1, 32'h80, 1'b0);
    chk("sat_fcnt", bus.flush_cnt, 32'hFFFF_FFFF);
    cyc(1'b0, 32'h0, 1'b0);
    chk("sat_hold", bus.flush_cnt, 32'hFFFF_FFFF);

    // async reset in the middle of a stall
    cyc(1'b0, 32'h0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_addr",  bus.irom_addr, 32'h0);
    chk("arst_valid", {31'b0, bus.id_valid}, 32'h0);
    chk("arst_fcnt",  bus.flush_cnt, 32'h0);
    chk("arst_scnt",  bus.stall_cnt, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0);
    chk("post_addr", bus.irom_addr, 32'h8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
